hilo_mult_unit: RTL and testbench
=================================

// Module: hilo_mult_unit
// PURPOSE
//  Execution side of MIPS MULT/MULTU: takes the decode-stage "is mult" indication plus
//  operands, computes the 64-bit product iteratively (one shift-add step per cycle) and
//  commits it to the HI/LO architectural registers. Sits beside the EX-stage ALU.
//  Drives a stall request so MFHI/MFLO never read a stale HI/LO mid-operation.
// PARAMETERS
//  WIDTH      32  operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk        in   1        rising-edge clock (single clock domain)
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        issue pulse: instruction is MULT/MULTU and EX not stalled
//  isSigned   in   1        1 = MULT (two's complement), 0 = MULTU
//  opA        in   WIDTH    rs operand, sampled only on accepted start
//  opB        in   WIDTH    rt operand, sampled only on accepted start
//  flush      in   1        pipeline flush; aborts an in-flight multiply
//  hiloRead   in   1        EX instruction is MFHI/MFLO
//  busy       out  1        high whenever state != IDLE
//  stall      out  1        hiloRead & busy (combinational)
//  done       out  1        one-cycle pulse in the cycle HI/LO are written
//  hi         out  WIDTH    HI register
//  lo         out  WIDTH    LO register
// BEHAVIOUR
//  Reset (async, any time incl. mid-op): state=IDLE, hi=lo=0, busy=done=0, counter=0,
//   working regs=0. Outputs valid immediately on reset assertion.
//  States: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 & flush=0 -> latch |opA|,|opB| (abs only when isSigned), latch
//         negate = isSigned & (opA[MSB]^opB[MSB]), clear accumulator, count=0, go RUN.
//   RUN:  each cycle: if multiplier LSB=1, acc += multiplicand<<count (2*WIDTH-bit add,
//         no overflow possible); shift multiplier right; count++. After WIDTH steps go FIX.
//   FIX:  product = negate ? -acc : acc (2*WIDTH two's complement); hi=product[2W-1:W],
//         lo=product[W-1:0]; done=1; go IDLE.
//  Latency: start accepted at cycle 0 -> done and new hi/lo visible at cycle WIDTH+1
//   (33 for WIDTH=32); next start accepted at cycle WIDTH+2.
//  start while busy: ignored (decode already stalls; unit must not corrupt in-flight op).
//  flush in RUN or FIX: return to IDLE next edge, hi/lo unchanged, no done pulse.
//   flush has priority over start in IDLE (start ignored).
//  Abs of most-negative (0x80000000): treated as unsigned 2^31, result exact.
//  hi/lo change only in FIX; never during RUN. done and busy both 1 in FIX.
//  stall deasserts in the cycle after FIX; MFHI/MFLO then read committed values.
// STRUCTURE
//  ISA.v: WORD/DWORD width macros, MULT state encodings (IDLE/RUN/FIX, 2 bits).
//  No separate sub-module required; optional hilo_mult_core for the shift-add datapath
//  (acc, multiplicand, multiplier, counter) with the FSM and HI/LO kept in the top.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
//  2 MULT 0xFFFFFFFF(-1)*0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; MULT 0x80000000*
//    0x80000000 -> hi=0x40000000, lo=0x00000000.
//  3 MULT 7*6, start re-pulsed with 3*3 at cycle 5 -> only hi=0, lo=0x2A committed.
//  4 MULTU 5*5, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep prior values.
//  5 reset asserted at cycle 15 of an op -> hi=lo=0, busy=0 same cycle; new op after works.
//  6 hiloRead held from cycle 1 -> stall=1 through cycle 33, 0 at cycle 34 with product.

Source files
------------

// File: rtl/hilo_mult_unit_pkg.sv
// Shared constants for the MULT/MULTU HI/LO unit: operand width default and FSM encodings.
package hilo_mult_unit_pkg;

    localparam int MULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/hilo_mult_unit_core.sv
// Shift-add datapath: one conditional add of the shifted multiplicand per step on magnitudes.
module hilo_mult_unit_core
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            count_d  = '0;
        end else if (step) begin
            // Shifting the multiplicand each step is the same as adding mcand << count.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    // NOTE: working registers are reset too, so nothing stale survives a mid-op reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign acc  = acc_q;
    assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// MULT/MULTU execution unit: IDLE->RUN->FIX sequencing, sign fix-up, HI/LO commit and stall.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    input  logic             hiloRead,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state_q, state_d;
    logic               negate_q, negate_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               load, step, last, commit;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] acc, product;

    // Magnitude of the most-negative value wraps to itself, which reads correctly as unsigned 2^(W-1).
    assign abs_a = (isSigned && opA[WIDTH-1]) ? -opA : opA;
    assign abs_b = (isSigned && opB[WIDTH-1]) ? -opB : opB;

    hilo_mult_unit_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .mcand_in  (abs_a),
        .mplier_in (abs_b),
        .acc       (acc),
        .last      (last)
    );

    assign product = negate_q ? -acc : acc;
    assign commit  = (state_q == ST_FIX) && !flush;

    always_comb begin
        state_d  = state_q;
        negate_d = negate_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    load     = 1'b1;
                    negate_d = isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (commit) begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            negate_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            negate_q <= negate_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // The committing FIX cycle forwards the product so done and the new HI/LO appear together.
    assign hi    = hi_d;
    assign lo    = lo_d;
    assign busy  = (state_q != ST_IDLE);
    assign done  = commit;
    assign stall = hiloRead & busy;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Randomized self-checking bench for hilo_mult_unit against a plain-arithmetic product model.
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, isSigned, flush, hiloRead;
    logic [W-1:0] opA, opB;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    hilo_mult_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .isSigned (isSigned),
        .opA      (opA),
        .opB      (opB),
        .flush    (flush),
        .hiloRead (hiloRead),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full operation: start in cycle 0, hiloRead held from cycle 1, checked through cycle 34.
    task automatic do_mult(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse);
        logic [63:0] p;
        p = ref_product(s, a, b);
        start = 1'b1; isSigned = s; opA = a; opB = b;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            next_cycle();
            if (cyc == 1) begin
                start = 1'b0; hiloRead = 1'b1;
                opA = $urandom; opB = $urandom; isSigned = $urandom_range(0, 1);
            end
            if (repulse && cyc == 5) begin
                start = 1'b1; opA = 32'd3; opB = 32'd3;
            end
            if (repulse && cyc == 6) start = 1'b0;
            #1;
            check("busy", 64'(busy), 64'(cyc <= 33));
            check("done", 64'(done), 64'(cyc == 33));
            check("stall", 64'(stall), 64'(cyc <= 33));
            if (cyc == 16) check("hilo_mid_run", {hi, lo}, {exp_hi, exp_lo});
            if (cyc == 33) check("hilo_at_done", {hi, lo}, p);
            if (cyc == 34) check("hilo_after", {hi, lo}, p);
        end
        hiloRead = 1'b0;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
    endtask

    // MULTU 5*5 flushed in cycle fc: no done, hi/lo untouched, idle the next cycle.
    task automatic flush_op(input int fc);
        start = 1'b1; isSigned = 1'b0; opA = 32'd5; opB = 32'd5;
        for (int cyc = 1; cyc <= fc + 1; cyc++) begin
            next_cycle();
            if (cyc == 1) start = 1'b0;
            if (cyc == fc) flush = 1'b1;
            if (cyc == fc + 1) flush = 1'b0;
            #1;
            check("flush_no_done", 64'(done), 64'h0);
            if (cyc == fc + 1) begin
                check("flush_idle", 64'(busy), 64'h0);
                check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
            end
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; isSigned = 1'b0; flush = 1'b0; hiloRead = 1'b0;
        opA = '0; opB = '0;
        next_cycle();
        next_cycle();
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        reset = 1'b0;
        next_cycle();

        do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_mult(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_mult(1'b1, 32'd7, 32'd6, 1'b1);
        check("repulse_lo", {hi, lo}, 64'h0000_0000_0000_002A);

        flush_op(10);
        flush_op(33);

        // Flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; opA = 32'd9; opB = 32'd9;
        next_cycle();
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_over_start", 64'(busy), 64'h0);

        // Asynchronous reset mid-operation.
        start = 1'b1; isSigned = 1'b0; opA = 32'h1234_5678; opB = 32'h9ABC_DEF0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            next_cycle();
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'h0);
        check("async_reset_busy", 64'(busy), 64'h0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        do_mult(1'b0, 32'd5, 32'd5, 1'b0);

        for (int i = 0; i < 25; i++) begin
            do_mult(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
